bitonic_stream_sorter: RTL

Sequential, streaming front-end/back-end for the 8-entry bitonic sorting network. It accepts 8 unsigned samples one per handshake and sorts them in place with a 4-comparator bitonic datapath over 6 clocked stages. It then drains the sorted result one sample per handshake. It sits between a byte-stream producer and consumer wherever the combinational 8-input sorter is too wide to instantiate or feed in parallel.

---
 rtl/bitonic_stream_sorter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bitonic_stream_sorter.sv
// Streaming 8-sample bitonic sorter: loads one sample per handshake and sorts
// in place over six clocked network stages. It then drains the sorted block one sample per handshake.
module bitonic_stream_sorter #(
    parameter int WIDTH   = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] e_q [8];
    logic [WIDTH-1:0] e_d [8];
    logic [2:0]       wr_idx_q, wr_idx_d;
    logic [2:0]       rd_idx_q, rd_idx_d;
    logic [2:0]       step_q, step_d;

    logic [3:0]       k;
    logic [2:0]       j;
    logic [2:0]       lo, hi;
    logic             asc;
    logic [2:0]       rd_sel;

    // Stage schedule (k = merge size, j = compare distance).
    always_comb begin
        k = 4'd8;
        j = 3'd1;
        case (step_q)
            3'd0: begin k = 4'd2; j = 3'd1; end
            3'd1: begin k = 4'd4; j = 3'd2; end
            3'd2: begin k = 4'd4; j = 3'd1; end
            3'd3: begin k = 4'd8; j = 3'd4; end
            3'd4: begin k = 4'd8; j = 3'd2; end
            default: begin k = 4'd8; j = 3'd1; end
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        step_d   = step_q;
        lo       = 3'd0;
        hi       = 3'd0;
        asc      = 1'b1;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    e_d[wr_idx_q] = in_data;
                    if (wr_idx_q == 3'd7) begin
                        state_d  = SORT;
                        wr_idx_d = 3'd0;
                        step_d   = 3'd0;
                    end else begin
                        wr_idx_d = wr_idx_q + 3'd1;
                    end
                end
            end
            SORT: begin
                for (int i = 0; i < 8; i++) begin
                    lo  = 3'(i);
                    hi  = lo ^ j;
                    // With k=8 no index has bit 3 set, so the whole stage is ascending.
                    asc = ((4'(lo) & k) == 4'd0);
                    if (lo < hi) begin
                        if (asc ? (e_q[lo] > e_q[hi]) : (e_q[lo] < e_q[hi])) begin
                            e_d[lo] = e_q[hi];
                            e_d[hi] = e_q[lo];
                        end
                    end
                end
                if (step_q == 3'd5) begin
                    state_d  = DRAIN;
                    rd_idx_d = 3'd0;
                    step_d   = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == 3'd7) begin
                        state_d  = LOAD;
                        rd_idx_d = 3'd0;
                    end else begin
                        rd_idx_d = rd_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the sample array is
    // reset too, so a block cut short by reset leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            wr_idx_q <= 3'd0;
            rd_idx_q <= 3'd0;
            step_q   <= 3'd0;
            for (int i = 0; i < 8; i++) e_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            step_q   <= step_d;
            e_q      <= e_d;
        end
    end

    always_comb begin
        rd_sel    = DESCEND ? (3'd7 - rd_idx_q) : rd_idx_q;
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == DRAIN);
        busy      = (state_q != LOAD);
        out_data  = out_valid ? e_q[rd_sel] : '0;
    end

endmodule
